// File: rtl/atp_pkg.sv
//------------------------------------------------------------------------------
// atp_pkg
//   Shared definitions for the card reader front end: reader state encoding,
//   serial frame constants, parameter defaults and a parity helper.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package atp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_START      = 3'd2,
    ST_DATA       = 3'd3,
    ST_PARITY     = 3'd4,
    ST_STOP       = 3'd5,
    ST_DELIVER    = 3'd6,
    ST_DONE       = 3'd7
  } reader_state_t;

  localparam int   DATA_BITS     = 8;
  localparam logic START_LEVEL   = 1'b0;
  localparam logic STOP_LEVEL    = 1'b1;
  localparam logic RX_IDLE_LEVEL = 1'b1;

  localparam int CLKS_PER_BIT_DEFAULT    = 16;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 8;
  localparam int TIMEOUT_CYCLES_DEFAULT  = 1024;

  // True when data plus parity bit carry an even number of ones.
  function automatic logic parity_ok(input logic [DATA_BITS-1:0] data,
                                     input logic                 par);
    return ~(^{data, par});
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_debounce.sv
//------------------------------------------------------------------------------
// sync_debounce
//   Two-flop synchronizer followed by a stability counter. The output only
//   follows the synchronized input after it has differed from the current
//   output for STABLE_CYCLES consecutive cycles.
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous active-low reset
//     din    in   raw asynchronous input
//     dout   out  synchronized, debounced level
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module sync_debounce #(
  parameter int   STABLE_CYCLES = 8,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int            CW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic          meta;
  logic          synced;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta   <= RESET_VALUE;
      synced <= RESET_VALUE;
      cnt    <= '0;
      dout   <= RESET_VALUE;
    end else begin
      meta   <= din;
      synced <= meta;
      // Any return to the accepted level restarts the stability window.
      if (synced == dout) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        dout <= synced;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/card_reader_frontend.sv
//------------------------------------------------------------------------------
// card_reader_frontend
//   Detects card insertion, receives one 8E1 serial ID byte from the card and
//   hands it to the payment controller. Exactly one result pulse
//   (card_inserted, card_error or card_timeout) per insertion.
//   Ports:
//     clk            in   system clock, rising edge
//     reset          in   asynchronous active-low reset
//     card_detect    in   raw card-present switch
//     card_rx        in   raw serial line from card (idles high)
//     ctrl_busy      in   controller not ready for a card
//     card_inserted  out  1-cycle pulse, card_data valid
//     card_data      out  last successfully received card ID
//     card_error     out  1-cycle pulse, parity/framing/removal error
//     card_timeout   out  1-cycle pulse, no start bit in time
//     reader_busy    out  high whenever not IDLE
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module card_reader_frontend
  import atp_pkg::*;
#(
  parameter int CLKS_PER_BIT    = CLKS_PER_BIT_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 card_detect,
  input  logic                 card_rx,
  input  logic                 ctrl_busy,
  output logic                 card_inserted,
  output logic [DATA_BITS-1:0] card_data,
  output logic                 card_error,
  output logic                 card_timeout,
  output logic                 reader_busy
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam int            NW        = $clog2(DATA_BITS);
  localparam logic [NW-1:0] IDX_LAST  = NW'(DATA_BITS - 1);

  reader_state_t        state, state_n;
  logic [BW-1:0]        baud_cnt, baud_n;
  logic [NW-1:0]        bit_cnt, bit_n;
  logic [TW-1:0]        tmo_cnt, tmo_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 perr, perr_n;
  logic                 ins_n, err_n, to_n;

  logic det, det_q, det_rise, det_fall;
  logic rx_meta, rx_s;

  sync_debounce #(
    .STABLE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VALUE   (1'b0)
  ) u_detect (
    .clk   (clk),
    .reset (reset),
    .din   (card_detect),
    .dout  (det)
  );

  // Serial line needs metastability protection only; bit sampling at
  // mid-bit already rejects short glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= RX_IDLE_LEVEL;
      rx_s    <= RX_IDLE_LEVEL;
      det_q   <= 1'b0;
    end else begin
      rx_meta <= card_rx;
      rx_s    <= rx_meta;
      det_q   <= det;
    end
  end

  assign det_rise = det & ~det_q;
  assign det_fall = ~det & det_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      tmo_cnt       <= '0;
      shift_reg     <= '0;
      perr          <= 1'b0;
      card_data     <= '0;
      card_inserted <= 1'b0;
      card_error    <= 1'b0;
      card_timeout  <= 1'b0;
    end else begin
      state         <= state_n;
      baud_cnt      <= baud_n;
      bit_cnt       <= bit_n;
      tmo_cnt       <= tmo_n;
      shift_reg     <= shift_n;
      perr          <= perr_n;
      card_data     <= data_n;
      card_inserted <= ins_n;
      card_error    <= err_n;
      card_timeout  <= to_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    tmo_n   = tmo_cnt;
    shift_n = shift_reg;
    perr_n  = perr;
    data_n  = card_data;
    ins_n   = 1'b0;
    err_n   = 1'b0;
    to_n    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (det_rise) begin
          state_n = ST_WAIT_START;
          tmo_n   = '0;
        end
      end
      ST_WAIT_START: begin
        if (rx_s == START_LEVEL) begin
          state_n = ST_START;
          baud_n  = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          to_n    = 1'b1;
          state_n = ST_DONE;
        end else begin
          tmo_n = tmo_cnt + 1'b1;
        end
      end
      ST_START: begin
        // Confirm the start bit at its centre; a high level here was noise,
        // and the timeout budget keeps running from where it stopped.
        if (baud_cnt == HALF_LAST) begin
          baud_n = '0;
          if (rx_s == START_LEVEL) begin
            state_n = ST_DATA;
            bit_n   = '0;
          end else begin
            state_n = ST_WAIT_START;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_cnt == BIT_LAST) begin
          baud_n  = '0;
          shift_n = {rx_s, shift_reg[DATA_BITS-1:1]};
          bit_n   = bit_cnt + 1'b1;
          if (bit_cnt == IDX_LAST) state_n = ST_PARITY;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_PARITY: begin
        if (baud_cnt == BIT_LAST) begin
          baud_n  = '0;
          perr_n  = ~parity_ok(shift_reg, rx_s);
          state_n = ST_STOP;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_cnt == BIT_LAST) begin
          baud_n = '0;
          if (perr || (rx_s != STOP_LEVEL)) begin
            err_n   = 1'b1;
            state_n = ST_DONE;
          end else begin
            state_n = ST_DELIVER;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_DELIVER: begin
        if (!ctrl_busy) begin
          data_n  = shift_reg;
          ins_n   = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        if (det_fall) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    // Card pulled before delivery wins over whatever the state wanted,
    // so only the removal error is reported for this insertion.
    if (det_fall && (state inside {ST_WAIT_START, ST_START, ST_DATA,
                                   ST_PARITY, ST_STOP, ST_DELIVER})) begin
      state_n = ST_IDLE;
      data_n  = card_data;
      ins_n   = 1'b0;
      to_n    = 1'b0;
      err_n   = 1'b1;
    end
  end

  assign reader_busy = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/card_reader_frontend.md
CARD_READER_FRONTEND -- requirements
Module: card_reader_frontend

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal values are even and at least 4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 8: cycles card_detect must hold stable before a change is accepted.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: cycles allowed from card accepted to start bit.
REQ-004 clk  in  1  single system clock; all logic on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 card_detect  in  1  raw card-present switch, asynchronous.
REQ-007 card_rx  in  1  raw serial line from card, asynchronous, idles high.
REQ-008 ctrl_busy  in  1  payment controller not ready to accept a card.
REQ-009 card_inserted  out  1  one-cycle pulse: card_data holds a valid card ID.
REQ-010 card_data  out  8  received card ID byte.
REQ-011 card_error  out  1  one-cycle pulse: parity, framing or removal error.
REQ-012 card_timeout  out  1  one-cycle pulse: no start bit within TIMEOUT_CYCLES.
REQ-013 reader_busy  out  1  high in every state except IDLE.

Function
REQ-014 card_detect and card_rx shall pass through 2-flop synchronizers; card_detect shall then be debounced over DEBOUNCE_CYCLES.
REQ-015 Frame format: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
REQ-016 FSM states: IDLE, WAIT_START, START, DATA, PARITY, STOP, DELIVER, DONE.
REQ-017 IDLE -> WAIT_START when debounced detect rises; the timeout counter clears on this transition.
REQ-018 WAIT_START: a synchronized card_rx low moves to START and loads the baud counter; reaching TIMEOUT_CYCLES pulses card_timeout and moves to DONE.
REQ-019 START: sample card_rx at CLKS_PER_BIT/2; if high, treat as a glitch and return to WAIT_START without resetting the timeout counter; if low, go to DATA.
REQ-020 DATA: sample every CLKS_PER_BIT cycles into a shift register with a 3-bit bit counter; after bit 7 go to PARITY.
REQ-021 PARITY: the sampled bit plus the 8 data bits shall have an even number of ones; on mismatch, flag a parity error and still go to STOP.
REQ-022 STOP: stop bit sampled 0 is a framing error; on any error pulse card_error and go to DONE; if clean, go to DELIVER.
REQ-023 DELIVER: while ctrl_busy is high, wait with no timeout; on the first cycle ctrl_busy is low, load card_data, pulse card_inserted for exactly one cycle, then go to DONE.
REQ-024 card_data shall change only on a card_inserted edge and hold its value until the next successful read.
REQ-025 DONE: exactly one read per insertion; stay until debounced detect falls, then go to IDLE.
REQ-026 Debounced detect falling in any of WAIT_START, START, DATA, PARITY, STOP or DELIVER shall pulse card_error and go to IDLE; no card_inserted is issued.
REQ-027 card_inserted, card_error and card_timeout are mutually exclusive; at most one fires per insertion.

Reset
REQ-028 While reset is low: state = IDLE; all counters = 0; card_data = 8'h00; card_inserted = card_error = card_timeout = reader_busy = 0; synchronizer flops set to idle values (detect 0, rx 1).
REQ-029 Reset asserted mid-frame shall abort immediately with no output pulse; after release, a card already present is re-detected through debounce.

Structure
REQ-030 A shared package atp_pkg shall hold the reader state enum, frame constants (DATA_BITS = 8, start/stop levels) and the parameter defaults.
REQ-031 One sub-module, sync_debounce (2-flop synchronizer plus stability counter), shall be instantiated for card_detect; card_rx shall use the synchronizer only.

Verification
REQ-032 Insert card, send 0xAB with parity 1, ctrl_busy = 0 -> one card_inserted pulse, card_data = 8'hAB, no error.
REQ-033 Send 0xCD with parity 0 -> card_error pulse, card_data unchanged (8'hAB), no card_inserted.
REQ-034 Insert card and send no frame for 1024 cycles -> card_timeout pulse at cycle 1024; reader_busy stays high until removal.
REQ-035 Send 0xEF (parity 1) while ctrl_busy = 1 for 100 cycles -> card_inserted only on the cycle after ctrl_busy falls, card_data = 8'hEF.
REQ-036 Remove the card after data bit 3 -> card_error pulse, state IDLE; a 3-cycle detect glitch produces no reaction.
REQ-037 Assert reset during DATA -> all outputs at reset values within the same cycle; a clean 0xAB read succeeds after release.
